// File: rtl/titan_id_hazard_unit.sv
// Decode-stage hazard tracker: shadows the destination registers of in-flight writers,
// picks forwarding sources for each ID operand and raises a load-use stall.
module titan_id_hazard_unit #(
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  id_valid_i,
  input  logic [5*NUM_SRC-1:0]                  id_rs_i,
  input  logic [NUM_SRC-1:0]                    id_rs_used_i,
  input  logic [4:0]                            id_rd_i,
  input  logic                                  id_we_i,
  input  logic                                  id_load_i,
  input  logic                                  id_flush_i,
  input  logic                                  trap_flush_i,
  input  logic                                  pipe_stall_i,
  output logic                                  id_stall_o,
  output logic [$clog2(DEPTH+1)*NUM_SRC-1:0]    fwd_sel_o,
  output logic [$clog2(DEPTH+1)-1:0]            inflight_o
);

  localparam int unsigned RW   = 5;
  localparam int unsigned SELW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rd;
    logic          load;
  } entry_t;

  entry_t [DEPTH-1:0] ent;
  logic               ins_c;
  logic               not_ready_c;

  // Lowest matching entry wins, so a younger writer shadows older ones.
  always_comb begin
    logic [RW-1:0]   rs;
    logic [SELW-1:0] sel;
    logic            nr;
    fwd_sel_o   = '0;
    not_ready_c = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      rs  = id_rs_i[RW*i +: RW];
      sel = '0;
      nr  = 1'b0;
      if (id_rs_used_i[i] && (rs != '0)) begin
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
          if (ent[k].valid && (ent[k].rd == rs)) begin
            sel = SELW'(k + 1);
            nr  = ent[k].load && (k < int'(LOAD_STAGE));
          end
        end
      end
      fwd_sel_o[SELW*i +: SELW] = sel;
      not_ready_c = not_ready_c | nr;
    end
  end

  assign id_stall_o = id_valid_i && !id_flush_i && not_ready_c;
  assign ins_c      = id_valid_i && id_we_i && (id_rd_i != '0) && !id_stall_o && !id_flush_i;

  // Writer shift register; trap flush beats downstream stall and insertion.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ent <= '0;
    end else if (trap_flush_i) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        ent[k].valid <= 1'b0;
      end
    end else if (!pipe_stall_i) begin
      for (int unsigned k = 1; k < DEPTH; k++) begin
        ent[k] <= ent[k-1];
      end
      ent[0].valid <= ins_c;
      ent[0].rd    <= id_rd_i;
      ent[0].load  <= id_load_i;
    end
  end

  always_comb begin
    inflight_o = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      inflight_o = inflight_o + SELW'(ent[k].valid);
    end
  end

endmodule

// File: doc/titan_id_hazard_unit.md
TITAN_ID_HAZARD_UNIT -- requirements
Module: titan_id_hazard_unit

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 2, giving the number of ID source-register ports.
REQ-002 The block SHALL have parameter DEPTH, default 3, giving the number of tracked downstream stages; entry 0 = EX, 1 = MEM, 2 = WB.
REQ-003 The block SHALL have parameter LOAD_STAGE, default 1, giving the first entry index at which load data is forwardable (1 <= LOAD_STAGE < DEPTH).
REQ-004 The block SHALL derive local SELW = clog2(DEPTH+1) for forward-select width.
REQ-005 Port clk_i  in  1  clock; all state on rising edge.
REQ-006 Port rst_i  in  1  asynchronous, active-low reset.
REQ-007 Port id_valid_i  in  1  ID holds a valid instruction.
REQ-008 Port id_rs_i  in  5*NUM_SRC  packed source addresses; port i at [5i+4:5i].
REQ-009 Port id_rs_used_i  in  NUM_SRC  source i is actually read by the instruction.
REQ-010 Port id_rd_i  in  5  destination of ID instruction.
REQ-011 Port id_we_i  in  1  ID instruction writes rd.
REQ-012 Port id_load_i  in  1  ID instruction is a load.
REQ-013 Port id_flush_i  in  1  kill the ID instruction (branch/jump taken).
REQ-014 Port trap_flush_i  in  1  kill all in-flight instructions (trap/xret).
REQ-015 Port pipe_stall_i  in  1  downstream stall; ID/EX and later registers hold.
REQ-016 Port id_stall_o  out  1  load-use hazard; ID must hold and insert a bubble.
REQ-017 Port fwd_sel_o  out  SELW*NUM_SRC  per-source select: 0 = register file, k+1 = entry k.
REQ-018 Port inflight_o  out  clog2(DEPTH+1)  number of valid tracked writers.

Function
REQ-019 The block SHALL hold DEPTH entries, each {valid, rd[4:0], load}.
REQ-020 An entry SHALL be valid only if its writer has we=1 and rd!=0.
REQ-021 On each rising edge with pipe_stall_i=0 and trap_flush_i=0, entry[k] SHALL take entry[k-1] for k>=1.
REQ-022 On the same edge, entry[0] SHALL take {1, id_rd_i, id_load_i} when id_valid_i & id_we_i & (id_rd_i!=0) & ~id_stall_o & ~id_flush_i, else a bubble (valid=0).
REQ-023 With pipe_stall_i=1 and trap_flush_i=0, all entries SHALL hold.
REQ-024 trap_flush_i=1 SHALL clear every valid bit on the next edge, overriding pipe_stall_i and any insertion.
REQ-025 For each source i with id_rs_used_i[i]=1 and rs!=0, the block SHALL find the lowest k with entry[k].valid & entry[k].rd==rs; fwd_sel_o[i] SHALL be k+1.
REQ-026 With no match, rs==0, or id_rs_used_i[i]=0, fwd_sel_o[i] SHALL be 0.
REQ-027 A match SHALL be not-ready when entry[k].load=1 and k<LOAD_STAGE.
REQ-028 id_stall_o SHALL be 1 iff id_valid_i=1, id_flush_i=0, and any source's lowest match is not-ready.
REQ-029 A younger ALU writer at lower k SHALL shadow an older load at higher k for the same rd, so no stall occurs.
REQ-030 id_stall_o and fwd_sel_o SHALL be combinational from current entries and inputs (zero-cycle latency).
REQ-031 inflight_o SHALL equal the popcount of entry valid bits.
REQ-032 A load-use pair SHALL stall exactly LOAD_STAGE cycles absent pipe_stall_i, after which fwd_sel_o selects entry LOAD_STAGE.

Reset
REQ-033 While rst_i=0, all entries SHALL clear asynchronously; inflight_o=0.
REQ-034 After reset with idle inputs, id_stall_o=0 and fwd_sel_o=0.
REQ-035 Reset deasserted mid-stall SHALL leave no residual stall; the first instruction after reset SHALL read the register file.

Verification
REQ-036 Insert add x5 (we=1, load=0), then ID reads rs1=x5 next cycle -> fwd_sel[0]=1, id_stall_o=0; next cycle fwd_sel=2, then 3, then 0.
REQ-037 Insert lw x7, then ID reads rs2=x7 -> id_stall_o=1 for 1 cycle, fwd_sel[1]=2 on the following cycle, inflight_o=1 during the bubble.
REQ-038 Sequence lw x3 then add x3, then ID reads x3 -> fwd_sel=1, no stall (shadowing).
REQ-039 rd=x0 writer, or rs=x0 read -> fwd_sel=0, inflight_o unchanged, no stall.
REQ-040 pipe_stall_i=1 for 3 cycles with entries {x5,x6,x7} -> entries and fwd_sel held; assert trap_flush_i concurrently -> inflight_o=0 next edge.
REQ-041 id_flush_i=1 with id_we_i=1, rd=x9 -> entry[0] becomes a bubble, and a later read of x9 gives fwd_sel=0.
